// File: rtl/alarm_chime_driver_if.sv
// alarm_chime_driver_if: alarm/acknowledge inputs and chime outputs of the chime driver
interface alarm_chime_driver_if #(parameter int BEEP_W = 4);
  logic              CarAlarmSignal;
  logic              ChimeAck;
  logic              BuzzerOut;
  logic              ChimeActive;
  logic              Silenced;
  logic [BEEP_W-1:0] BeepCount;
  modport master (output CarAlarmSignal, ChimeAck, input BuzzerOut, ChimeActive, Silenced, BeepCount);
  modport slave (input CarAlarmSignal, ChimeAck, output BuzzerOut, ChimeActive, Silenced, BeepCount);
endinterface

// File: rtl/alarm_chime_driver.sv
// alarm_chime_driver: debounces the car alarm and drives a capped, acknowledgeable beep pattern
module alarm_chime_driver #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ON_CYCLES       = 8,
  parameter int OFF_CYCLES      = 8,
  parameter int MAX_BEEPS       = 5,
  parameter int CNT_W           = 8,
  parameter int BEEP_W          = 4
) (
  input logic                 clk,
  input logic                 reset_L,
  alarm_chime_driver_if.slave chime
);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ARM      = 3'd1;
  localparam logic [2:0] BEEP_ON  = 3'd2;
  localparam logic [2:0] BEEP_OFF = 3'd3;
  localparam logic [2:0] SILENT   = 3'd4;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);
  localparam logic [BEEP_W-1:0] MAX_B   = BEEP_W'(MAX_BEEPS);
  logic [2:0]        r_state, w_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt;
  logic [BEEP_W-1:0] r_beeps, w_beeps, w_beeps_inc;
  logic              r_buzz, r_active, r_silent;
  logic              w_sig, w_ack;
  assign w_sig       = chime.CarAlarmSignal;
  assign w_ack       = chime.ChimeAck;
  assign w_beeps_inc = r_beeps + 1'b1;
  // Loss of the alarm always wins over an acknowledge arriving on the same edge.
  always_comb begin
    w_nxt   = r_state;
    w_cnt   = r_cnt;
    w_beeps = r_beeps;
    case (r_state)
      IDLE: if (w_sig) begin
        w_nxt = (DEBOUNCE_CYCLES == 1) ? BEEP_ON : ARM;
        w_cnt = (DEBOUNCE_CYCLES == 1) ? '0 : CNT_W'(1);
      end
      ARM: begin
        w_nxt = !w_sig ? IDLE : (r_cnt >= DEB_LAST) ? BEEP_ON : ARM;
        w_cnt = (w_nxt == ARM) ? r_cnt + 1'b1 : '0;
      end
      BEEP_ON: begin
        w_nxt   = !w_sig ? IDLE : w_ack ? SILENT : (r_cnt < ON_LAST) ? BEEP_ON :
                  (w_beeps_inc == MAX_B) ? SILENT : BEEP_OFF;
        w_beeps = (w_sig && !w_ack && r_cnt >= ON_LAST) ? w_beeps_inc : r_beeps;
        w_cnt   = (w_nxt == BEEP_ON) ? r_cnt + 1'b1 : '0;
      end
      BEEP_OFF: begin
        w_nxt = !w_sig ? IDLE : w_ack ? SILENT : (r_cnt < OFF_LAST) ? BEEP_OFF : BEEP_ON;
        w_cnt = (w_nxt == BEEP_OFF) ? r_cnt + 1'b1 : '0;
      end
      SILENT: begin
        w_nxt = w_sig ? SILENT : IDLE;
        w_cnt = '0;
      end
      default: begin
        w_nxt = IDLE;
        w_cnt = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_beeps  <= '0;
      r_buzz   <= 1'b0;
      r_active <= 1'b0;
      r_silent <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      r_cnt    <= w_cnt;
      r_beeps  <= (w_nxt == IDLE) ? '0 : w_beeps;
      r_buzz   <= (w_nxt == BEEP_ON);
      r_active <= (w_nxt == BEEP_ON) || (w_nxt == BEEP_OFF);
      r_silent <= (w_nxt == SILENT);
    end
  end
  assign chime.BuzzerOut   = r_buzz;
  assign chime.ChimeActive = r_active;
  assign chime.Silenced    = r_silent;
  assign chime.BeepCount   = r_beeps;
endmodule

// File: tb/tb_alarm_chime_driver.sv
// tb_alarm_chime_driver: directed scenarios for the alarm chime driver at default parameters
module tb_alarm_chime_driver;
  logic clk = 1'b0;
  logic reset_L = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  logic [6:0] w_obs;
  alarm_chime_driver_if bus ();
  alarm_chime_driver dut (.clk(clk), .reset_L(reset_L), .chime(bus));
  always #5 clk = ~clk;
  assign w_obs = {bus.BuzzerOut, bus.ChimeActive, bus.Silenced, bus.BeepCount};
  function automatic logic [6:0] e(bit b, bit a, bit s, int n);
    return {b, a, s, 4'(n)};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    bus.CarAlarmSignal = 1'b1;
    bus.ChimeAck = 1'b0;
    reset_L = 1'b0;
    tick();
    tick();
    n_checks++;
    if (w_obs !== e(0, 0, 0, 0)) begin n_fail++; $display("FAIL reset_outputs: got %b want %b", w_obs, e(0, 0, 0, 0)); end
    reset_L = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (w_obs !== e(0, 0, 0, 0)) begin n_fail++; $display("FAIL reset_debounce3: got %b want %b", w_obs, e(0, 0, 0, 0)); end
    tick();
    n_checks++;
    if (w_obs !== e(1, 1, 0, 0)) begin n_fail++; $display("FAIL reset_debounce4: got %b want %b", w_obs, e(1, 1, 0, 0)); end
    bus.CarAlarmSignal = 1'b0;
    tick();
    n_checks++;
    if (w_obs !== e(0, 0, 0, 0)) begin n_fail++; $display("FAIL reset_drop: got %b want %b", w_obs, e(0, 0, 0, 0)); end
  endtask
  task automatic test_glitch();
    for (int r = 0; r < 2; r++) begin
      bus.CarAlarmSignal = 1'b1;
      for (int i = 0; i < 3; i++) begin
        tick();
        n_checks++;
        if (w_obs !== e(0, 0, 0, 0)) begin n_fail++; $display("FAIL glitch_high r%0d c%0d: got %b want %b", r, i, w_obs, e(0, 0, 0, 0)); end
      end
      bus.CarAlarmSignal = 1'b0;
      tick();
      n_checks++;
      if (w_obs !== e(0, 0, 0, 0)) begin n_fail++; $display("FAIL glitch_low r%0d: got %b want %b", r, w_obs, e(0, 0, 0, 0)); end
    end
  endtask
  task automatic test_full_episode();
    bus.CarAlarmSignal = 1'b1;
    repeat (4) tick();
    for (int b = 0; b < 5; b++) begin
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (w_obs !== e(1, 1, 0, b)) begin n_fail++; $display("FAIL episode_on b%0d c%0d: got %b want %b", b, i, w_obs, e(1, 1, 0, b)); end
        tick();
      end
      if (b < 4) begin
        for (int i = 0; i < 8; i++) begin
          n_checks++;
          if (w_obs !== e(0, 1, 0, b + 1)) begin n_fail++; $display("FAIL episode_off b%0d c%0d: got %b want %b", b, i, w_obs, e(0, 1, 0, b + 1)); end
          tick();
        end
      end
    end
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if (w_obs !== e(0, 0, 1, 5)) begin n_fail++; $display("FAIL episode_silent c%0d: got %b want %b", i, w_obs, e(0, 0, 1, 5)); end
      tick();
    end
    bus.CarAlarmSignal = 1'b0;
    tick();
    n_checks++;
    if (w_obs !== e(0, 0, 0, 0)) begin n_fail++; $display("FAIL episode_end: got %b want %b", w_obs, e(0, 0, 0, 0)); end
  endtask
  task automatic test_ack();
    bus.CarAlarmSignal = 1'b1;
    repeat (4) tick();
    repeat (18) tick();
    n_checks++;
    if (w_obs !== e(1, 1, 0, 1)) begin n_fail++; $display("FAIL ack_beep2_c3: got %b want %b", w_obs, e(1, 1, 0, 1)); end
    bus.ChimeAck = 1'b1;
    tick();
    bus.ChimeAck = 1'b0;
    n_checks++;
    if (w_obs !== e(0, 0, 1, 1)) begin n_fail++; $display("FAIL ack_silence: got %b want %b", w_obs, e(0, 0, 1, 1)); end
    bus.ChimeAck = 1'b1;
    repeat (12) tick();
    bus.ChimeAck = 1'b0;
    n_checks++;
    if (w_obs !== e(0, 0, 1, 1)) begin n_fail++; $display("FAIL ack_hold: got %b want %b", w_obs, e(0, 0, 1, 1)); end
    bus.CarAlarmSignal = 1'b0;
    tick();
    n_checks++;
    if (w_obs !== e(0, 0, 0, 0)) begin n_fail++; $display("FAIL ack_release: got %b want %b", w_obs, e(0, 0, 0, 0)); end
    bus.CarAlarmSignal = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (w_obs !== e(0, 0, 0, 0)) begin n_fail++; $display("FAIL ack_rearm3: got %b want %b", w_obs, e(0, 0, 0, 0)); end
    tick();
    n_checks++;
    if (w_obs !== e(1, 1, 0, 0)) begin n_fail++; $display("FAIL ack_rearm4: got %b want %b", w_obs, e(1, 1, 0, 0)); end
  endtask
  task automatic test_simultaneous();
    repeat (8) tick();
    n_checks++;
    if (w_obs !== e(0, 1, 0, 1)) begin n_fail++; $display("FAIL simul_off: got %b want %b", w_obs, e(0, 1, 0, 1)); end
    repeat (2) tick();
    bus.CarAlarmSignal = 1'b0;
    bus.ChimeAck = 1'b1;
    tick();
    bus.ChimeAck = 1'b0;
    n_checks++;
    if (w_obs !== e(0, 0, 0, 0)) begin n_fail++; $display("FAIL simul_idle: got %b want %b", w_obs, e(0, 0, 0, 0)); end
  endtask
  task automatic test_reset_mid_beep();
    bus.CarAlarmSignal = 1'b1;
    bus.ChimeAck = 1'b1;
    repeat (3) tick();
    bus.ChimeAck = 1'b0;
    tick();
    n_checks++;
    if (w_obs !== e(1, 1, 0, 0)) begin n_fail++; $display("FAIL midrst_ack_arm: got %b want %b", w_obs, e(1, 1, 0, 0)); end
    repeat (4) tick();
    n_checks++;
    if (w_obs !== e(1, 1, 0, 0)) begin n_fail++; $display("FAIL midrst_c5: got %b want %b", w_obs, e(1, 1, 0, 0)); end
    reset_L = 1'b0;
    tick();
    n_checks++;
    if (w_obs !== e(0, 0, 0, 0)) begin n_fail++; $display("FAIL midrst_reset: got %b want %b", w_obs, e(0, 0, 0, 0)); end
    reset_L = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (w_obs !== e(0, 0, 0, 0)) begin n_fail++; $display("FAIL midrst_debounce3: got %b want %b", w_obs, e(0, 0, 0, 0)); end
    tick();
    n_checks++;
    if (w_obs !== e(1, 1, 0, 0)) begin n_fail++; $display("FAIL midrst_debounce4: got %b want %b", w_obs, e(1, 1, 0, 0)); end
  endtask
  initial begin
    bus.CarAlarmSignal = 1'b0;
    bus.ChimeAck = 1'b0;
    test_reset();
    test_glitch();
    test_full_episode();
    test_ack();
    test_simultaneous();
    test_reset_mid_beep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alarm_chime_driver.md
# alarm_chime_driver

Downstream stage of the car alarm logic: consumes the combinational `CarAlarmSignal` and turns it into a timed, audible chime. The block debounces the alarm condition, pulses a buzzer with fixed on and off periods, and caps the number of beeps. It also lets the driver silence the chime with an acknowledge input. All outputs are registered, so glitches on the combinational alarm never reach the buzzer.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive high samples of `CarAlarmSignal` required before chiming (≥1).
- `ON_CYCLES`, default 8: buzzer-high cycles per beep (≥1).
- `OFF_CYCLES`, default 8: buzzer-low cycles between beeps (≥1).
- `MAX_BEEPS`, default 5: beeps before automatic silence (1..2^BEEP_W−1).
- `CNT_W`, default 8: width of the shared cycle counter; must hold max(DEBOUNCE_CYCLES, ON_CYCLES, OFF_CYCLES).
- `BEEP_W`, default 4: width of `BeepCount`.
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset_L` in 1: synchronous, active-low reset.
- `CarAlarmSignal` in 1: alarm condition from the alarm logic (lights on, door open, ignition off).
- `ChimeAck` in 1: driver acknowledge; mutes the chime for the current alarm episode.
- `BuzzerOut` out 1: buzzer drive.
- `ChimeActive` out 1: high while in BEEP_ON or BEEP_OFF.
- `Silenced` out 1: high while in SILENT.
- `BeepCount` out BEEP_W: completed beeps in the current episode.

## Operation
- States: IDLE, ARM, BEEP_ON, BEEP_OFF, SILENT. One cycle counter `cnt` is cleared on every state entry.
- Reset (`reset_L`=0 at a rising edge): state IDLE, `cnt`=0, and all outputs 0. Reset overrides every other input, including a reset asserted mid-beep.
- IDLE:
  - `CarAlarmSignal`=1 → ARM with `cnt`=1.
  - If DEBOUNCE_CYCLES=1, go directly to BEEP_ON.
- ARM:
  - `CarAlarmSignal`=0 → IDLE.
  - Otherwise increment `cnt`. When the sample that makes `cnt` reach DEBOUNCE_CYCLES is high → BEEP_ON.
- BEEP_ON:
  - Stay ON_CYCLES cycles.
  - At the end of the ON period, increment `BeepCount`. If the new value equals MAX_BEEPS → SILENT; otherwise → BEEP_OFF.
- BEEP_OFF: stay OFF_CYCLES cycles, then → BEEP_ON.
- Abort in BEEP_ON or BEEP_OFF (priority order):
  1. `CarAlarmSignal`=0 → IDLE.
  2. `ChimeAck`=1 → SILENT.
  - Both events in the same cycle → IDLE.
- SILENT: hold. `CarAlarmSignal`=0 → IDLE. `ChimeAck` is ignored.
- Entering IDLE clears `BeepCount` to 0. `BeepCount` holds its value in SILENT.
- Output decode, registered from the next state:
  - `BuzzerOut` = (state==BEEP_ON).
  - `ChimeActive` = BEEP_ON or BEEP_OFF.
  - `Silenced` = SILENT.
- `ChimeAck` in IDLE or ARM has no effect.

## Timing
- Debounce latency: first high sample at edge k → `BuzzerOut`=1 after edge k+DEBOUNCE_CYCLES−1.
- A glitch shorter than DEBOUNCE_CYCLES samples never asserts `BuzzerOut`.
- Beep shape: `BuzzerOut` high for exactly ON_CYCLES cycles, then low for exactly OFF_CYCLES cycles. Period is ON_CYCLES+OFF_CYCLES.
- `BeepCount` updates on the same edge that drops `BuzzerOut`.
- Abort latency: `CarAlarmSignal` or `ChimeAck` sampled at edge n → `BuzzerOut`=0 after edge n.
- No chime resumes until `CarAlarmSignal` has been low for at least one sample and then satisfies the debounce again.
- Counters never wrap: `cnt` stops at each terminal count, and `BeepCount` stops at MAX_BEEPS.

## Test plan
- Reset: `reset_L`=0 for 2 cycles while `CarAlarmSignal`=1 → all outputs 0. Release, then 4 high samples → `BuzzerOut`=1 after the 4th edge.
- Glitch rejection: `CarAlarmSignal` high for 3 cycles, then low → `BuzzerOut` stays 0 and state returns to IDLE.
- Full episode, defaults, alarm held high:
  - Five 8-cycle high pulses on `BuzzerOut`, separated by 8-cycle lows.
  - `BeepCount` steps 1..5.
  - After the 5th pulse: `Silenced`=1, `ChimeActive`=0, `BuzzerOut` stays 0.
- Acknowledge: `ChimeAck` pulsed in cycle 3 of beep 2 → `BuzzerOut`=0 and `Silenced`=1 on the next edge, `BeepCount`=1. Then drop the alarm for 1 cycle and re-raise for 4 → new episode with `BeepCount` starting at 0.
- Simultaneous events: `CarAlarmSignal`=0 and `ChimeAck`=1 on the same edge during BEEP_OFF → IDLE, `Silenced`=0, `BeepCount`=0.
- Reset mid-beep: `reset_L`=0 during BEEP_ON cycle 5 → all outputs 0 on that edge. After release with the alarm still high → full debounce again, 4 cycles.
